// File: rtl/vliw_hazard_track.sv
// ============================================================================
// vliw_hazard_track: per-stage destination tracking for both issue slots plus
// ID stall/flush control. Optional macro: VLIW_STALL_STATS_EN (stall counter).
// Revision: 1.0
// ============================================================================
`default_nettype none

module vliw_hazard_track #(
  parameter int RW  = 5,
  parameter int SCW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs1,
  input  logic [RW-1:0] id_rs2,
  input  logic [RW-1:0] id_rsc,
  input  logic          id_regwr,
  input  logic          id_regwrc,
  input  logic [RW-1:0] id_regdest,
  input  logic [RW-1:0] id_regdestc,
  input  logic          id_memrd,
  input  logic          id_branch,
  input  logic          id_jump,
  input  logic          branch_taken,
  input  logic          jump_taken,
  output logic          stall,
  output logic          flush,
  output logic          p2_regwr1,
  output logic          p2_regwr2,
  output logic [RW-1:0] p2_regdest,
  output logic [RW-1:0] p2_regdestc,
  output logic          p3_regwr,
  output logic          p3_regwrc,
  output logic [RW-1:0] p3_regdest,
  output logic [RW-1:0] p3_regdestc,
`ifdef VLIW_STALL_STATS_EN
  output logic [SCW-1:0] stall_cycles,
`endif
  output logic          p3_memwr
);

  typedef struct packed {
    logic          regwr;
    logic          regwrc;
    logic [RW-1:0] regdest;
    logic [RW-1:0] regdestc;
    logic          memrd;
  } rec_t;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  if (RW < 1 || SCW < 1) begin : g_param_check
    $error("vliw_hazard_track: RW and SCW must be positive");
  end

  rec_t       p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       flush_q, flush_d;

  logic       is_ctrl;
  logic       any_match;
  logic       ld_hit;
  logic       h1, h2;
  logic       hazard;

  function automatic logic match(input rec_t p, input logic [RW-1:0] r);
    return (r != '0) &&
           ((p.regwr && (p.regdest == r)) || (p.regwrc && (p.regdestc == r)));
  endfunction

  function automatic logic ld_match(input rec_t p, input logic [RW-1:0] r);
    return (r != '0) && (p.regdest == r);
  endfunction

  always_comb begin
    is_ctrl   = id_branch | id_jump;
    any_match = match(p1_q, id_rs1) | match(p1_q, id_rs2) | match(p1_q, id_rsc);
    ld_hit    = ld_match(p1_q, id_rs1) | ld_match(p1_q, id_rs2) | ld_match(p1_q, id_rsc);
    h2        = is_ctrl & p1_q.memrd & any_match;
    h1        = (p1_q.memrd & ld_hit) | (is_ctrl & any_match);
    hazard    = id_valid & (state_q == ST_RUN) & (h1 | h2);
  end

  // cnt is the total stall length including the detection cycle; HOLD is only
  // needed for the cycles beyond it, so a 1-cycle hazard stays in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    if (state_q == ST_RUN) begin
      if (hazard) begin
        stall   = 1'b1;
        cnt_d   = h2 ? 2'd2 : 2'd1;
        state_d = h2 ? ST_HOLD : ST_RUN;
      end
    end else begin
      stall = 1'b1;
      cnt_d = cnt_q - 2'd1;
      if (cnt_q <= 2'd2) begin
        state_d = ST_RUN;
      end
    end
  end

  always_comb begin
    p1_d = '0;
    if (id_valid && !stall && !flush_q) begin
      p1_d.regwr    = id_regwr;
      p1_d.regwrc   = id_regwrc;
      p1_d.regdest  = id_regdest;
      p1_d.regdestc = id_regdestc;
      p1_d.memrd    = id_memrd;
    end
    p2_d    = p1_q;
    p3_d    = p2_q;
    // A stalled bundle re-issues, so its redirect is acted on only once it moves.
    flush_d = (branch_taken | jump_taken) & ~stall;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p1_q    <= '0;
      p2_q    <= '0;
      p3_q    <= '0;
      state_q <= ST_RUN;
      cnt_q   <= 2'd0;
      flush_q <= 1'b0;
    end else begin
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      p3_q    <= p3_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
    end
  end

`ifdef VLIW_STALL_STATS_EN
  logic [SCW-1:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + SCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

  assign flush       = flush_q;
  assign p2_regwr1   = p2_q.regwr;
  assign p2_regwr2   = p2_q.regwrc;
  assign p2_regdest  = p2_q.regdest;
  assign p2_regdestc = p2_q.regdestc;
  assign p3_regwr    = p3_q.regwr;
  assign p3_regwrc   = p3_q.regwrc;
  assign p3_regdest  = p3_q.regdest;
  assign p3_regdestc = p3_q.regdestc;
  assign p3_memwr    = p3_q.memrd;

endmodule

`default_nettype wire
